regfile_dump_unit: RTL and testbench

//  Synthesizable register-file snapshot engine; successor to the bench's periodic register print.

---
 rtl/regfile_dump_pkg.sv | 30 +++
 rtl/dump_period_timer.sv | 35 +++
 rtl/regfile_dump_unit.sv | 166 ++++++++++++++++
 tb/tb_regfile_dump_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file snapshot engine.
//  state_t    : walk FSM states
//  dump_rec_t : {idx, data} record at the default 32 x 32 geometry
//  SNAP_CNT_W : width of the completed-snapshot counter
//  first_index: first register index a walk visits
package regfile_dump_pkg;

    localparam int SNAP_CNT_W   = 16;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_IDX_W-1:0]  idx;
        logic [DEF_DATA_W-1:0] data;
    } dump_rec_t;

    // Register 0 is hard-wired to zero on most CPUs, so a walk may skip it.
    function automatic int first_index(input bit skip_r0);
        return skip_r0 ? 1 : 0;
    endfunction

endpackage

// File: rtl/dump_period_timer.sv
// Periodic snapshot request generator.
//  clk    : clock
//  reset  : synchronous active-high reset, clears the count
//  enable : count advances only while high
//  tick   : one-cycle request when the count wraps from PERIOD-1 to 0
// PERIOD = 0 disables the timer entirely (tick tied low).
module dump_period_timer #(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    generate
        if (PERIOD == 0) begin : g_off
            assign tick = 1'b0;
        end else begin : g_on
            localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            logic [TW-1:0] timer_reg;

            assign tick = enable && (timer_reg == TW'(PERIOD - 1));

            always_ff @(posedge clk) begin
                if (reset) begin
                    timer_reg <= '0;
                end else if (enable) begin
                    timer_reg <= tick ? '0 : timer_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/regfile_dump_unit.sv
// Register-file snapshot engine. Walks the register file through a read
// port and streams {index, value} records over a valid/ready interface,
// either every register (full) or only those changed since the last
// snapshot (diff).
//  clk, reset            : clock, synchronous active-high reset
//  enable                : periodic request timer runs while high
//  trigger               : one-shot request, level sampled each cycle
//  diff_mode             : latched at snapshot start
//  rf_raddr / rf_rdata   : register-file read port (combinational data)
//  dump_valid/ready      : record handshake
//  dump_idx / dump_data  : record payload, stable while valid & !ready
//  snap_done             : one-cycle pulse while the walk finishes
//  snap_count            : completed snapshots (wrapping)
//  overrun               : sticky, a request was dropped
module regfile_dump_unit
    import regfile_dump_pkg::*;
#(
    parameter int  NUM_REGS = 32,
    parameter int  DATA_W   = 32,
    parameter int  PERIOD   = 2,
    parameter bit  SKIP_R0  = 1'b1,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  trigger,
    input  logic                  diff_mode,
    output logic [IDX_W-1:0]      rf_raddr,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [IDX_W-1:0]      dump_idx,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  snap_done,
    output logic [SNAP_CNT_W-1:0] snap_count,
    output logic                  overrun
);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } rec_t;

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(first_index(SKIP_R0));
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

    state_t                  state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic                    diff_reg;
    logic                    shadow_valid_reg;
    logic                    pending_reg;
    logic                    overrun_reg;
    logic                    dump_valid_reg;
    logic                    snap_done_reg;
    logic [SNAP_CNT_W-1:0]   snap_count_reg;
    rec_t                    rec_reg;
    logic [DATA_W-1:0]       shadow_mem [NUM_REGS];

    logic period_tick;
    logic req;
    logic last_idx;
    logic emit_now;
    logic handshake;

    dump_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (period_tick)
    );

    // Trigger and timer in the same cycle merge into a single request.
    assign req       = trigger | period_tick;
    assign last_idx  = (idx_reg == LAST_IDX);
    assign handshake = dump_valid_reg & dump_ready;
    // Shadow is meaningless until a complete walk has refreshed it.
    assign emit_now  = !diff_reg || !shadow_valid_reg || (rf_rdata != shadow_mem[idx_reg]);

    assign rf_raddr   = idx_reg;
    assign dump_valid = dump_valid_reg;
    assign dump_idx   = rec_reg.idx;
    assign dump_data  = rec_reg.data;
    assign snap_done  = snap_done_reg;
    assign snap_count = snap_count_reg;
    assign overrun    = overrun_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            diff_reg         <= 1'b0;
            shadow_valid_reg <= 1'b0;
            pending_reg      <= 1'b0;
            overrun_reg      <= 1'b0;
            dump_valid_reg   <= 1'b0;
            snap_done_reg    <= 1'b0;
            snap_count_reg   <= '0;
            rec_reg          <= '0;
        end else begin
            snap_done_reg <= 1'b0;

            // Requests arriving while a walk is in flight use the single
            // pending slot; a second one is dropped and flagged.
            if (state_reg != IDLE && req) begin
                if (!pending_reg) begin
                    pending_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (req || pending_reg) begin
                        state_reg <= SCAN;
                        idx_reg   <= FIRST_IDX;
                        diff_reg  <= diff_mode;
                        // Starting consumes the pending slot; a fresh
                        // request in the same cycle takes its place.
                        pending_reg <= pending_reg & req;
                    end
                end
                SCAN: begin
                    if (emit_now) begin
                        rec_reg        <= '{idx: idx_reg, data: rf_rdata};
                        dump_valid_reg <= 1'b1;
                        state_reg      <= EMIT;
                    end else if (last_idx) begin
                        state_reg     <= DONE;
                        snap_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        dump_valid_reg <= 1'b0;
                        if (last_idx) begin
                            state_reg     <= DONE;
                            snap_done_reg <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= SCAN;
                        end
                    end
                end
                DONE: begin
                    snap_count_reg   <= snap_count_reg + 1'b1;
                    shadow_valid_reg <= 1'b1;
                    state_reg        <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Shadow holds the last value delivered for each register; contents are
    // not reset because shadow_valid_reg gates their use.
    always_ff @(posedge clk) begin
        if (state_reg == EMIT && handshake) begin
            shadow_mem[rec_reg.idx] <= rec_reg.data;
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Self-checking bench for regfile_dump_unit: directed scenarios with random
// register contents, checked against a record-level reference model.
module tb_regfile_dump_unit;

    localparam int N  = 32;
    localparam int W  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset, enable, trigger, diff_mode, dump_ready;
    logic [IW-1:0] rf_raddr;
    logic [W-1:0]  rf_rdata;
    logic          dump_valid, snap_done, overrun;
    logic [IW-1:0] dump_idx;
    logic [W-1:0]  dump_data;
    logic [15:0]   snap_count;

    always #5 clk = ~clk;

    logic [W-1:0] rf [N];
    assign rf_rdata = rf[rf_raddr];

    regfile_dump_unit #(.NUM_REGS(N), .DATA_W(W), .PERIOD(40), .SKIP_R0(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .trigger    (trigger),
        .diff_mode  (diff_mode),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .snap_done  (snap_done),
        .snap_count (snap_count),
        .overrun    (overrun)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } rec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t got_q[$];
    rec_t exp_q[$];
    logic [W-1:0] sh [N];     // model of last-delivered values
    bit   sv;                 // model shadow validity
    int   exp_count;
    int   done_cnt;
    int   rdy_mode;           // 0: always ready, 1: ready 1-of-3, 2: never ready
    int   cyc;
    bit   hold;
    logic [IW-1:0] h_idx;
    logic [W-1:0]  h_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample outputs at negedge, then drive inputs after posedge.
    task automatic tick();
        @(negedge clk);
        if (hold) begin
            check("stable_valid", {63'd0, dump_valid}, 64'd1);
            check("stable_idx",   {59'd0, dump_idx}, {59'd0, h_idx});
            check("stable_data",  {32'd0, dump_data}, {32'd0, h_data});
        end
        if (dump_valid === 1'b1 && dump_ready) got_q.push_back('{int'(dump_idx), dump_data});
        hold   = (dump_valid === 1'b1) && !dump_ready;
        h_idx  = dump_idx;
        h_data = dump_data;
        if (snap_done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        case (rdy_mode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = (cyc % 3 == 0);
            default: dump_ready = 1'b0;
        endcase
    endtask

    task automatic add_expected(input bit diff);
        for (int i = 1; i < N; i++)
            if (!diff || !sv || rf[i] !== sh[i]) exp_q.push_back('{i, rf[i]});
    endtask

    task automatic wait_done(input int d0, input int n, input string tag);
        for (int k = 0; k < 3000 && done_cnt - d0 < n; k++) tick();
        repeat (3) tick();
        check({tag, "_done"}, 64'(done_cnt - d0), 64'(n));
    endtask

    task automatic compare_records(input string tag);
        check({tag, "_nrec"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                check({tag, "_idx"},  64'(got_q[i].idx), 64'(exp_q[i].idx));
                check({tag, "_data"}, {32'd0, got_q[i].data}, {32'd0, exp_q[i].data});
            end
        end
        foreach (exp_q[i]) sh[exp_q[i].idx] = exp_q[i].data;
        sv = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic snapshot(input bit diff, input int mode, input string tag);
        int d0;
        exp_q.delete();
        got_q.delete();
        add_expected(diff);
        rdy_mode  = mode;
        diff_mode = diff;
        d0        = done_cnt;
        trigger   = 1'b1;
        tick();
        trigger   = 1'b0;
        diff_mode = ~diff;    // mid-walk change must be ignored
        wait_done(d0, 1, tag);
        compare_records(tag);
        exp_count++;
        check({tag, "_count"}, {48'd0, snap_count}, 64'(exp_count & 16'hFFFF));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hold  = 1'b0;
        got_q.delete();
        sv        = 1'b0;
        exp_count = 0;
        check("rst_valid",   {63'd0, dump_valid}, 64'd0);
        check("rst_count",   {48'd0, snap_count}, 64'd0);
        check("rst_overrun", {63'd0, overrun}, 64'd0);
        check("rst_raddr",   {59'd0, rf_raddr}, 64'd0);
        check("rst_done",    {63'd0, snap_done}, 64'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b1; enable = 1'b0; trigger = 1'b0; diff_mode = 1'b0; dump_ready = 1'b1;
        rdy_mode = 0; cyc = 0; hold = 1'b0; done_cnt = 0; sv = 1'b0; exp_count = 0;
        for (int i = 0; i < N; i++) rf[i] = W'(i * 3);
        tick();
        do_reset();

        // 1: full dump of r[i] = 3i
        snapshot(1'b0, 0, "t1_full");

        // 2: diff mode after two writes, then with no writes
        rf[5] = 99; rf[20] = 7;
        snapshot(1'b1, 0, "t2_diff");
        snapshot(1'b1, 0, "t2_nochg");

        // 3: backpressure, random contents, full then diff
        for (int i = 1; i < N; i++) rf[i] = $urandom;
        snapshot(1'b0, 1, "t3_bp_full");
        for (int k = 0; k < 4; k++) rf[$urandom_range(N - 1, 1)] = $urandom;
        snapshot(1'b1, 1, "t3_bp_diff");

        // 4: trigger held 3 cycles mid-walk -> one pending walk, overrun
        exp_q.delete(); got_q.delete();
        add_expected(1'b0); add_expected(1'b0);
        rdy_mode = 0; diff_mode = 1'b0; d0 = done_cnt;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (5) tick();
        trigger = 1'b1; repeat (3) tick(); trigger = 1'b0;
        wait_done(d0, 2, "t4_ovr");
        compare_records("t4_ovr");
        exp_count += 2;
        check("t4_overrun", {63'd0, overrun}, 64'd1);
        check("t4_count", {48'd0, snap_count}, 64'(exp_count));

        // 5: periodic requests at 40,80,120,160,200 -> 4 walks, one drop
        do_reset();
        exp_q.delete(); got_q.delete();
        repeat (4) add_expected(1'b0);
        rdy_mode = 0; diff_mode = 1'b0; d0 = done_cnt;
        enable = 1'b1;
        repeat (200) tick();
        enable = 1'b0;
        wait_done(d0, 4, "t5_per");
        repeat (80) tick();
        check("t5_nwalks", 64'(done_cnt - d0), 64'd4);
        compare_records("t5_per");
        check("t5_overrun", {63'd0, overrun}, 64'd1);
        check("t5_count", {48'd0, snap_count}, 64'd4);

        // 6: reset while a record is stalled, then diff must be full
        rdy_mode = 2;
        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 0; k < 20 && dump_valid !== 1'b1; k++) tick();
        check("t6_valid_seen", {63'd0, dump_valid}, 64'd1);
        do_reset();
        snapshot(1'b1, 0, "t6_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
